// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame state encoding and bit-timing helpers.
// The transmitter reuses the same encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Number of clocks to the middle of a bit, used to centre the start-bit check.
    function automatic int half_bit_clks(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchroniser: a STAGES-deep flop chain with a programmable reset value.
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: synchronised line in, parallel byte out via a
// level valid/ack handshake, with sticky overrun and a one-cycle framing-error pulse.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a falling edge on the synchronised line
//   ST_START | counting to mid start bit, rejecting glitches that read high
//   ST_DATA  | sampling WIDTH data bits LSB first, one per bit period
//   ST_STOP  | sampling the stop bit, then commit the byte or flag a frame error
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_line,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(half_bit_clks(CLKS_PER_BIT) - 1);
    localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("uart_rx: SYNC_STAGES must be >= 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("uart_rx: WIDTH must be >= 2");
    end

    uart_state_e      state;
    uart_state_e      state_nxt;
    logic             s;
    logic             s_prev;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] shift;

    logic start_edge;
    logic half_tc;
    logic bit_tc;
    logic sample_bit;
    logic stop_tc;
    logic commit;
    logic stop_bad;

    // Idle-high line: synchroniser presets to 1 so reset never fakes a start edge.
    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_line),
        .q     (s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_edge) state_nxt = ST_START;
            ST_START: if (half_tc) state_nxt = s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (sample_bit && (bit_idx == LAST_IDX)) state_nxt = ST_STOP;
            ST_STOP:  if (stop_tc) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        start_edge = s_prev & ~s;
        half_tc    = (state == ST_START) && (cnt == HALF_TC);
        bit_tc     = (cnt == BIT_TC);
        sample_bit = (state == ST_DATA) && bit_tc;
        stop_tc    = (state == ST_STOP) && bit_tc;
        commit     = stop_tc && s;
        stop_bad   = stop_tc && !s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_prev    <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            s_prev    <= s;
            frame_err <= stop_bad;

            if ((state == ST_IDLE) || half_tc || sample_bit || stop_tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state != ST_DATA) begin
                bit_idx <= '0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 1'b1;
            end

            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            if (sample_bit) begin
                shift <= {s, shift[WIDTH-1:1]};
            end

            // A commit outranks a same-cycle ack: the new byte stays valid.
            if (commit) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule
